rr_stream_mux: RTL and testbench

RR_STREAM_MUX -- requirements
Module: rr_stream_mux

---
 rtl/rr_stream_mux_pkg.sv | 12 +
 rtl/rr_stream_mux_arbiter.sv | 42 ++++
 rtl/rr_stream_mux.sv | 78 +++++++
 tb/tb_rr_stream_mux.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: mode encoding
// and the select-index width helper.
package rr_stream_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// One-hot grant generator: round-robin search from ptr, or fixed priority
// with the lowest index winning.
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter int N_CH = 8,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  logic [SEL_W-1:0] start;
  logic [N_CH-1:0]  req_hi;
  logic [N_CH-1:0]  pick;

  // Requests at or above the start point win first; otherwise wrap to the bottom.
  always_comb begin
    start  = (mode == MODE_RR) ? ptr : '0;
    req_hi = '0;
    for (int k = 0; k < N_CH; k++) begin
      req_hi[k] = req[k] && (SEL_W'(k) >= start);
    end
    pick    = (|req_hi) ? req_hi : req;
    gnt     = '0;
    gnt_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (pick[k]) begin
        gnt     = '0;
        gnt[k]  = 1'b1;
        gnt_idx = SEL_W'(k);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with a single registered output
// stage, selectable round-robin or fixed-priority arbitration.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int WIDTH = 8,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nxt;
  logic [N_CH-1:0]  gnt_p0;
  logic [SEL_W-1:0] idx_p0;
  logic             any_p0;
  logic [WIDTH-1:0] data_p0;
  logic             ld;

  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] sel_p1;
  logic             vld_p1;

  // p0: arbitration and data selection
  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .mode    (mode),
    .gnt     (gnt_p0),
    .gnt_idx (idx_p0),
    .any     (any_p0)
  );

  always_comb begin
    data_p0 = '0;
    for (int k = 0; k < N_CH; k++) begin
      data_p0 = data_p0 | (in_data[k*WIDTH +: WIDTH] & {WIDTH{gnt_p0[k]}});
    end
  end

  assign ld       = !vld_p1 || out_ready;
  assign in_ready = (ld && rst_n) ? gnt_p0 : '0;
  assign ptr_nxt  = (idx_p0 == SEL_W'(N_CH - 1)) ? '0 : idx_p0 + SEL_W'(1);

  // p1: output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
      ptr     <= '0;
    end else if (ld) begin
      vld_p1 <= any_p0;
      if (any_p0) begin
        data_p1 <= data_p0;
        sel_p1  <= idx_p0;
        ptr     <= ptr_nxt;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_sel   = sel_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Randomised and directed bench for rr_stream_mux against a queue-free
// behavioural model of the arbitration rules.
module tb_rr_stream_mux;

  localparam int N = 8;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic         mode;
  logic [W-1:0] out_data;
  logic [2:0]   out_sel;
  logic         out_valid;
  logic         out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  logic         m_vld;
  logic [W-1:0] m_data;
  logic [2:0]   m_sel;
  int           m_ptr;

  rr_stream_mux #(.N_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic int exp_grant(input logic [N-1:0] v, input logic md, input int p);
    int start;
    start = md ? 0 : p;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (start + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = exp_grant(in_valid, mode, m_ptr);
    if ((!m_vld || out_ready) && g >= 0) return N'(1 << g);
    return '0;
  endfunction

  task automatic model_reset();
    m_vld  = 1'b0;
    m_data = '0;
    m_sel  = '0;
    m_ptr  = 0;
  endtask

  task automatic set_default_data();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = 8'hA0 + W'(k);
  endtask

  task automatic tick();
    int g;
    @(posedge clk);
    if (!m_vld || out_ready) begin
      g = exp_grant(in_valid, mode, m_ptr);
      if (g >= 0) begin
        m_vld  = 1'b1;
        m_data = in_data[g*W +: W];
        m_sel  = 3'(g);
        m_ptr  = (g + 1) % N;
      end else begin
        m_vld = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; out_ready = 1'b1; in_valid = 8'hFF;
    set_default_data();
    model_reset();
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_tests++;
    if (out_data !== 8'h00 || out_sel !== 3'd0) begin
      n_fail++; $display("FAIL reset_out_data_sel got=%h/%0d want=00/0", out_data, out_sel);
    end
    n_tests++;
    if (in_ready !== 8'h00) begin n_fail++; $display("FAIL reset_in_ready got=%h want=00", in_ready); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rr_full();
    mode = 1'b0; in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      n_tests++;
      if (in_ready !== N'(1 << (i % N))) begin
        n_fail++; $display("FAIL rr_full_in_ready[%0d] got=%h want=%h", i, in_ready, N'(1 << (i % N)));
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_sel !== 3'(i % N) || out_data !== 8'hA0 + W'(i % N)) begin
        n_fail++;
        $display("FAIL rr_full_out[%0d] got=%b/%0d/%h want=1/%0d/%h", i, out_valid, out_sel, out_data,
                 i % N, 8'hA0 + W'(i % N));
      end
    end
  endtask

  task automatic test_fixed();
    mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (out_sel !== 3'd0 || out_data !== 8'hA0 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL fixed_all[%0d] got=%0d/%h want=0/a0", i, out_sel, out_data);
      end
    end
    in_valid = 8'b0110_0000;
    tick();
    n_tests++;
    if (out_sel !== 3'd5 || out_data !== 8'hA5) begin
      n_fail++; $display("FAIL fixed_sparse got=%0d/%h want=5/a5", out_sel, out_data);
    end
  endtask

  task automatic test_sparse_rr();
    int want[3] = '{5, 2, 5};
    mode = 1'b0; out_ready = 1'b1;
    in_valid = 8'b0000_0100;
    tick();
    in_valid = 8'b0010_0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (out_sel !== 3'(want[i]) || out_sel !== m_sel) begin
        n_fail++; $display("FAIL sparse_rr[%0d] got=%0d want=%0d", i, out_sel, want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; in_valid = 8'hFF; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (in_ready !== 8'h00) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%h want=00", i, in_ready); end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_sel !== m_sel || out_data !== m_data) begin
        n_fail++; $display("FAIL bp_hold[%0d] got=%b/%0d/%h want=1/%0d/%h", i, out_valid, out_sel, out_data, m_sel, m_data);
      end
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== N'(1 << m_ptr)) begin
      n_fail++; $display("FAIL bp_resume got=%h want=%h", in_ready, N'(1 << m_ptr));
    end
    tick();
  endtask

  task automatic test_mode_switch();
    mode = 1'b0; out_ready = 1'b1; in_valid = 8'b0001_0000;
    tick();
    n_tests++;
    if (out_sel !== 3'd4) begin n_fail++; $display("FAIL mode_pre got=%0d want=4", out_sel); end
    mode = 1'b1; in_valid = 8'hFF;
    tick();
    n_tests++;
    if (out_sel !== 3'd0) begin n_fail++; $display("FAIL mode_fixed got=%0d want=0", out_sel); end
    mode = 1'b0;
    tick();
    n_tests++;
    if (out_sel !== 3'd1) begin n_fail++; $display("FAIL mode_back_rr got=%0d want=1", out_sel); end
  endtask

  task automatic test_reset_mid();
    mode = 1'b0; in_valid = 8'hFF; out_ready = 1'b1;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 3'd0 || in_ready !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset got=%b/%h/%0d/%h want=0/00/0/00", out_valid, out_data, out_sel, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 8'h01) begin n_fail++; $display("FAIL mid_reset_ready got=%h want=01", in_ready); end
    tick();
    n_tests++;
    if (out_sel !== 3'd0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_first got=%0d/%b want=0/1", out_sel, out_valid);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] want;
    for (int c = 0; c < 400; c++) begin
      mode      = ($urandom_range(0, 5) == 0);
      in_valid  = N'($urandom & $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
      #1;
      want = exp_ready();
      n_tests++;
      if (in_ready !== want) begin
        n_fail++; $display("FAIL rand_in_ready[%0d] got=%h want=%h", c, in_ready, want);
      end
      tick();
      n_tests++;
      if (out_valid !== m_vld || out_sel !== m_sel || out_data !== m_data) begin
        n_fail++;
        $display("FAIL rand_out[%0d] got=%b/%0d/%h want=%b/%0d/%h", c, out_valid, out_sel, out_data, m_vld, m_sel, m_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_full();
    test_fixed();
    test_sparse_rr();
    test_backpressure();
    test_mode_switch();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
